// File: rtl/fetch_pkg.sv
// Shared LC-3 definitions: word width and the control-flow opcodes
// that steer the program counter.
package fetch_pkg;

    localparam int WORD_W = 16;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b1100;

    function automatic logic [WORD_W-1:0] sext9(input logic [8:0] v);
        return {{(WORD_W-9){v[8]}}, v};
    endfunction

endpackage

// File: rtl/fetch.sv
// LC-3 fetch unit: program counter register plus next-PC selection
// for sequential flow, conditional branch, JMP/RET and JSR/JSRR.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_start,
    input  logic [3:0]        opCode_in,
    input  logic [8:0]        offset_in,
    input  logic [WORD_W-1:0] reg_in,
    input  logic [2:0]        br_nzp,
    input  logic [2:0]        result_nzp,
    output logic [WORD_W-1:0] addr_out,
    output logic              wea_out,
    output logic [WORD_W-1:0] pc
);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;
    logic [WORD_W-1:0] pc_inc;
    logic [WORD_W-1:0] next_pc;
    logic              br_taken;

    always_comb begin
        pc_inc   = pc_q + 16'd1;
        br_taken = |(br_nzp & result_nzp);
        next_pc  = pc_inc;
        case (opCode_in)
            OP_BR:   next_pc = br_taken ? pc_inc + sext9(offset_in) : pc_inc;
            OP_JMP:  next_pc = reg_in;
            OP_JSR:  next_pc = reg_in;
            default: next_pc = pc_inc;
        endcase
        pc_d = fetch_start ? next_pc : pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc       = pc_q;
    assign addr_out = pc_q;
    assign wea_out  = 1'b0;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed vector table, reset corner
// cases, and randomized traffic against an arithmetic reference model.
module tb_fetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_start;
    logic [3:0]  opCode_in;
    logic [8:0]  offset_in;
    logic [15:0] reg_in;
    logic [2:0]  br_nzp;
    logic [2:0]  result_nzp;
    logic [15:0] addr_out;
    logic        wea_out;
    logic [15:0] pc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        fs;
        logic [3:0]  op;
        logic [8:0]  off;
        logic [15:0] rg;
        logic [2:0]  br;
        logic [2:0]  res;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    fetch #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_start (fetch_start),
        .opCode_in   (opCode_in),
        .offset_in   (offset_in),
        .reg_in      (reg_in),
        .br_nzp      (br_nzp),
        .result_nzp  (result_nzp),
        .addr_out    (addr_out),
        .wea_out     (wea_out),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: LC-3 next-PC rules in plain integer arithmetic mod 2^16
    function automatic int ref_next(int cur, logic fs, logic [3:0] op,
                                    logic [8:0] off, logic [15:0] rg,
                                    logic [2:0] br, logic [2:0] res);
        int soff;
        int r;
        if (!fs) return cur;
        soff = int'(off);
        if (soff >= 256) soff = soff - 512;
        if (op == 4'd12 || op == 4'd4) return int'(rg);
        r = cur + 1;
        if (op == 4'd0) begin
            if ((br[2] && res[2]) || (br[1] && res[1]) || (br[0] && res[0]))
                r = r + soff;
        end
        r = ((r % 65536) + 65536) % 65536;
        return r;
    endfunction

    task automatic check(string name, logic [15:0] exp);
        checks++;
        if (pc !== exp || addr_out !== exp || wea_out !== 1'b0) begin
            failures++;
            $display("FAIL %s: pc=%h addr_out=%h wea_out=%b, want pc=addr_out=%h wea_out=0",
                     name, pc, addr_out, wea_out, exp);
        end
    endtask

    task automatic drive(logic fs, logic [3:0] op, logic [8:0] off,
                         logic [15:0] rg, logic [2:0] br, logic [2:0] res);
        fetch_start = fs;
        opCode_in   = op;
        offset_in   = off;
        reg_in      = rg;
        br_nzp      = br;
        result_nzp  = res;
    endtask

    initial begin
        int model_pc;

        drive(1'b0, 4'd0, 9'd0, 16'd0, 3'd0, 3'd0);
        rst_n = 1'b0;
        #1;
        check("reset_async", 16'h0000);
        repeat (5) @(posedge clk);
        #1;
        check("reset_hold", 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", 16'h0000);

        vecs.push_back('{"seq1",   1'b1, 4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0001});
        vecs.push_back('{"seq2",   1'b1, 4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0002});
        vecs.push_back('{"seq3",   1'b1, 4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0003});
        vecs.push_back('{"brzp_t", 1'b1, 4'b0000, 9'h005, 16'h0000, 3'b011, 3'b010, 16'h0009});
        vecs.push_back('{"brzp_n", 1'b1, 4'b0000, 9'h005, 16'h0000, 3'b011, 3'b100, 16'h000A});
        vecs.push_back('{"brn_neg",1'b1, 4'b0000, 9'h1FC, 16'h0000, 3'b100, 3'b100, 16'h0007});
        vecs.push_back('{"hold",   1'b0, 4'b1100, 9'h1FF, 16'h1234, 3'b111, 3'b111, 16'h0007});
        vecs.push_back('{"jmp",    1'b1, 4'b1100, 9'h000, 16'hFFFF, 3'b000, 3'b000, 16'hFFFF});
        vecs.push_back('{"wrap",   1'b1, 4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000, 16'h0000});
        vecs.push_back('{"br_nop", 1'b1, 4'b0000, 9'h0FF, 16'h0000, 3'b000, 3'b111, 16'h0001});
        vecs.push_back('{"jsrr",   1'b1, 4'b0100, 9'h000, 16'h0040, 3'b000, 3'b000, 16'h0040});

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].fs, vecs[i].op, vecs[i].off, vecs[i].rg,
                  vecs[i].br, vecs[i].res);
            @(posedge clk);
            #1;
            check(vecs[i].name, vecs[i].exp_pc);
        end

        // Reset between edges with fetch_start pending
        @(negedge clk);
        drive(1'b1, 4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_async", 16'h0000);
        @(posedge clk);
        #1;
        check("reset_over_fetch", 16'h0000);
        @(negedge clk);
        fetch_start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_hold", 16'h0000);

        // Randomized traffic against the reference model
        model_pc = 0;
        for (int i = 0; i < 300; i++) begin
            logic        fs;
            logic [3:0]  op;
            logic [8:0]  off;
            logic [15:0] rg;
            logic [2:0]  br;
            logic [2:0]  res;
            int          sel;
            fs  = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 5);
            op  = (sel == 0) ? 4'd12 : (sel == 1) ? 4'd4 :
                  (sel <= 3) ? 4'd0 : 4'($urandom_range(0, 15));
            off = 9'($urandom);
            rg  = 16'($urandom);
            br  = 3'($urandom);
            res = 3'($urandom);
            @(negedge clk);
            drive(fs, op, off, rg, br, res);
            @(posedge clk);
            #1;
            model_pc = ref_next(model_pc, fs, op, off, rg, br, res);
            check($sformatf("rand%0d", i), 16'(model_pc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, giving the PC value loaded on reset.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port fetch_start, input, 1 bit: one-cycle request to advance the PC for the instruction just executed.
REQ-006 Port opCode_in, input, 4 bits: opcode of the instruction just executed.
REQ-007 Port offset_in, input, 9 bits: PCoffset9 field of the instruction just executed.
REQ-008 Port reg_in, input, 16 bits: BaseR register value, used by JMP/RET and JSRR.
REQ-009 Port br_nzp, input, 3 bits: n/z/p condition mask from the BR instruction, in order n=bit2, z=bit1, p=bit0.
REQ-010 Port result_nzp, input, 3 bits: current condition codes, in the same bit order as br_nzp.
REQ-011 Port addr_out, output, 16 bits: instruction-memory address.
REQ-012 Port wea_out, output, 1 bit: instruction-memory write enable.
REQ-013 Port pc, output, 16 bits: current program counter.

Function
REQ-014 pc SHALL be a 16-bit register; addr_out SHALL always equal pc (combinational copy).
REQ-015 wea_out SHALL be constant 0, because fetch only reads memory.
REQ-016 When fetch_start=0, pc SHALL hold its value; opCode_in, offset_in, reg_in, br_nzp and result_nzp SHALL be ignored.
REQ-017 On a rising edge with fetch_start=1, pc SHALL load next_pc; the new value is visible the cycle after the request (1-cycle latency).
REQ-018 BR (4'b0000): if (br_nzp & result_nzp) != 0, next_pc SHALL be pc + 1 + sign-extended offset_in; otherwise next_pc SHALL be pc + 1.
REQ-019 BR with br_nzp=3'b000 SHALL never branch (NOP).
REQ-020 JMP/RET (4'b1100): next_pc SHALL be reg_in.
REQ-021 JSR/JSRR (4'b0100): next_pc SHALL be reg_in; the link register is handled outside this block.
REQ-022 All other opcodes: next_pc SHALL be pc + 1.
REQ-023 All next_pc arithmetic SHALL be modulo 2^16: 16'hFFFF + 1 wraps to 16'h0000, and negative offsets wrap below 0.
REQ-024 next_pc SHALL be computed combinationally from the current inputs and pc; no input is registered.
REQ-025 Back-to-back fetch_start pulses on consecutive cycles SHALL each advance pc once.

Reset
REQ-026 While rst_n=0, pc SHALL be RESET_PC immediately, independent of clk; addr_out SHALL equal RESET_PC and wea_out SHALL be 0.
REQ-027 A reset asserted mid-operation SHALL override a simultaneous fetch_start.
REQ-028 After rst_n deasserts, pc SHALL hold RESET_PC until the first fetch_start.

Structure
REQ-029 Opcode constants (OP_BR=4'b0000, OP_JSR=4'b0100, OP_JMP=4'b1100) SHALL live in the shared LC-3 package, alongside the 16-bit word width.
REQ-030 The block SHALL be a single module with no sub-modules: a next-PC combinational block plus the PC register.

Verification
REQ-031 Reset: rst_n=0 for 5 cycles, then released with fetch_start=0 -> addr_out=0, wea_out=0, pc=0.
REQ-032 Sequential fetch: opCode_in=4'b0001 with 3 fetch_start pulses from pc=0 -> pc=1, 2, 3; addr_out tracks pc.
REQ-033 BRzp taken: pc=3, br_nzp=3'b011, result_nzp=3'b010, offset_in=9'h005, fetch_start -> pc=16'h0009.
REQ-034 BRzp not taken and negative branch: with result_nzp=3'b100, pc=9 -> pc=10; then BRn with offset_in=9'h1FC -> pc=7.
REQ-035 JMP and wrap: opCode_in=4'b1100, reg_in=16'hFFFF -> pc=16'hFFFF; next ADD -> pc=16'h0000.
REQ-036 Reset mid-run: rst_n asserted between clock edges while pc=16'h0040 -> pc=0 immediately, and wea_out stays 0 throughout.
